// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between a CPU-side master and the
// mem_responder slave. One request in flight at a time; valid/ready on both
// the request and the response channel.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // CPU side: issues requests, consumes responses
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory side: accepts requests, produces responses
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory with a fixed response latency.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, then the
// response is held in RESP until the CPU takes it. Loads sample the array and
// stores commit on the edge entering RESP, so a reset before that edge drops
// the store. Addresses wrap modulo DEPTH*4 bytes.
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to reject misaligned
// addresses (no write, resp_err=1, resp_rdata=0); otherwise addr[1:0] are
// ignored and resp_err is tied low.
module mem_responder #(
  parameter int DEPTH   = 256, // 32-bit words, power of two, >= 4
  parameter int LATENCY = 2    // wait cycles, 0..15
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        enter_resp;

  // Request fields captured at acceptance
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Effective request: live inputs when committing straight from IDLE
  // (LATENCY==0), otherwise the captured copy.
  logic        eff_write;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [AW-1:0] idx;
  logic        misaligned;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  // Select between live and captured request fields
  always_comb begin
    if (state_q == IDLE) begin
      eff_write = bus.req_write;
      eff_addr  = bus.req_addr;
      eff_wdata = bus.req_wdata;
    end else begin
      eff_write = lat_write;
      eff_addr  = lat_addr;
      eff_wdata = lat_wdata;
    end
  end

  assign idx = eff_addr[AW+1:2];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned = |eff_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Upper address bits alias away; byte-offset bits matter only with the check
  logic unused_addr_bits;
  assign unused_addr_bits = ^{eff_addr[31:AW+2], eff_addr[1:0]};

  // State register and latency counter
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and commit-strobe decode
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request so later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end
  end

  // Storage array; stores commit only on the edge entering RESP
  // NOTE: the array has no reset; only the commit is gated so a reset
  // mid-transaction drops an uncommitted store.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && eff_write && !misaligned) begin
      mem[idx] <= eff_wdata;
    end
  end

  // Response data/error: loaded on entering RESP, cleared on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= (eff_write || misaligned) ? 32'd0 : mem[idx];
      err_q   <= misaligned;
    end else if (state_q == RESP && bus.resp_ready) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, 256, number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter LATENCY, 2, wait cycles between request acceptance and response; range 0..15.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, as listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  CPU-side request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  CPU accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned access flag; constant 0 when REQ-029 is compiled out.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL equal (state==IDLE).
REQ-016 A request is accepted on an edge where req_valid && req_ready; the responder SHALL latch write, addr and wdata at that edge.
REQ-017 On acceptance, the FSM SHALL go to WAIT and load the down-counter with LATENCY; if LATENCY==0, it SHALL go directly to RESP.
REQ-018 In WAIT, the counter SHALL decrement each cycle; when it reaches 1, the FSM SHALL go to RESP on the next edge.
REQ-019 resp_valid SHALL be asserted exactly LATENCY+1 cycles after the accepting edge.
REQ-020 Word index = addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses alias modulo DEPTH*4 bytes.
REQ-021 A load SHALL capture mem[index] into resp_rdata on the edge entering RESP.
REQ-022 A store SHALL write the latched wdata to mem[index] on the edge entering RESP, never earlier.
REQ-023 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready.
REQ-024 On response handshake, the FSM SHALL return to IDLE and clear resp_valid, resp_rdata and resp_err.
REQ-025 req_valid asserted during the handshake cycle is not accepted; acceptance SHALL occur no earlier than the following edge, giving a minimum request spacing of LATENCY+2 cycles.
REQ-026 req_valid, req_addr and other request inputs outside IDLE SHALL be ignored.

Reset
REQ-027 On any edge with reset=1: state SHALL become IDLE, the counter 0, resp_valid 0, resp_rdata 0, resp_err 0, and req_ready SHALL read 1 from the next cycle.
REQ-028 Reset mid-transaction SHALL abandon the transaction: an uncommitted store is dropped. Memory contents are not reset.

Configuration
REQ-029 Macro MEM_RESPONDER_ALIGN_CHECK_EN:
- Defined: a request with addr[1:0]!=0 follows normal timing, performs no memory write, and responds with resp_err=1 and resp_rdata=0.
- Undefined: addr[1:0] are ignored, the access proceeds normally, and resp_err is tied to 0.

Verification (DEPTH=256, LATENCY=2, macro defined unless noted)
REQ-030 Store 0x10 = 0xDEADBEEF, then load 0x10 -> each resp_valid rises 3 cycles after acceptance; the load returns 0xDEADBEEF with resp_err 0.
REQ-031 Load with resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready 0 throughout; IDLE one cycle after resp_ready=1.
REQ-032 Store 0x400 = 0x00000001, then load 0x0 -> 0x00000001 (aliasing).
REQ-033 Store 0x13 = 0xFFFFFFFF -> resp_err 1, rdata 0; a load of 0x10 then returns the prior value. With the macro undefined, the same store updates word 4 and resp_err is 0.
REQ-034 Store 0x20 = 0x12345678 with reset pulsed in WAIT, then load 0x20 -> old value; resp_valid is 0 the cycle after reset.
